// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master, one-slave Wishbone arbiter with a per-access timeout.
//
// The two masters (m0, m1) share one slave. Only one master owns the bus at a
// time. Ownership lasts for the owner's whole bus cycle (cyc high), and
// ownership alternates round-robin when both masters request together.
// ack, read data and err are returned to the owner only.
// If a strobed access waits TIMEOUT_CYCLES cycles without an ack, the owner
// gets a one-cycle err pulse. This covers accesses to addresses the slave
// never acks.
//
// Ports:
//   wb_clk_i, wb_rst_n_i          clock, asynchronous active-low reset
//   m0_* / m1_*                   master cyc/stb/we/adr/dat in; ack/err/dat out
//   s_cyc_o .. s_dat_o            request muxed from the owner to the slave
//   s_ack_i, s_sta_i, s_dat_i     slave ack, stall and read data
//   grant_o                       one-hot owner {m1, m0}; 00 when idle
//
// Handshake: a slave access is in flight while s_cyc_o & s_stb_o.
// Each cycle with s_ack_i high completes one access for the owner.
// The state is visible on grant_o: 00=IDLE, 01=OWN0, 10=OWN1.
module wb_arbiter_2m #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic        s_sta_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             own0, own1;
  logic             own_cyc, own_stb;
  logic             waiting;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  // A stalled cycle is still a cycle without an ack.
  // An ack always ends the wait, even when the same cycle is stalled.
  assign waiting = (s_sta_i | ~s_ack_i) & ~s_ack_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;   // m0 wins the first tie after reset
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic. A release always passes through IDLE,
  // so two owners are separated by at least one idle cycle.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_owner_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timeout counter. It counts only while an owned strobe is waiting.
  // Any other cycle clears it, and so does the err pulse itself.
  // This means a master that keeps stb high after an err is timed again from 0.
  always_comb begin
    cnt_d = '0;
    err_d = 1'b0;
    if (own_cyc && own_stb && !err_q && waiting) begin
      if (cnt_q == CNT_LAST) err_d = 1'b1;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Request mux toward the slave and the return path toward the masters.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (own0) begin
      own_cyc  = m0_cyc_i;
      own_stb  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_dat_o = s_dat_i;
    end else if (own1) begin
      own_cyc  = m1_cyc_i;
      own_stb  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_dat_o = s_dat_i;
    end
  end

  assign s_cyc_o  = own_cyc;
  assign s_stb_o  = own_stb & ~err_q;   // no strobe in the err cycle
  assign m0_ack_o = s_ack_i & own0;
  assign m1_ack_o = s_ack_i & own1;
  // If the owner has already dropped cyc, the err is not delivered.
  assign m0_err_o = err_q & own0 & m0_cyc_i;
  assign m1_err_o = err_q & own1 & m1_cyc_i;
  assign grant_o  = {own1, own0};

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i = 0, s_sta_i = 0;
  logic [31:0] s_dat_i = '0;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  wb_arbiter_2m #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_sta_i(s_sta_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change 2ns after the rising edge, outputs are sampled 1ns later
  task automatic step();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic set_master(input int m, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  // A single access by master m. The slave acks after `delay` owned strobe cycles.
  // Writes push the write data, which is checked at the slave port.
  // Reads push the slave data, which is checked on the owner's dat_o in the ack cycle.
  task automatic access(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] wd, input int delay, input logic [31:0] rd);
    logic [1:0]  g;
    logic [31:0] e;
    int n;
    g = (m == 0) ? 2'b01 : 2'b10;
    step();
    set_master(m, 1, 1, we, adr, wd);
    exp_q.push_back(we ? wd : rd);
    n = 0;
    do begin step(); #1; n++; end while (grant_o !== g && n < 8);
    check("grant_latency", n, 1);
    check("grant", {30'd0, grant_o}, {30'd0, g});
    check("s_adr", s_adr_o, adr);
    check("s_we", {31'd0, s_we_o}, {31'd0, we});
    if (we) begin
      e = exp_q.pop_front();
      check("s_dat", s_dat_o, e);
    end
    for (int i = 0; i < delay; i++) begin
      check("wait_no_ack", {31'd0, m0_ack_o | m1_ack_o}, 32'd0);
      check("wait_stb", {31'd0, s_stb_o}, 32'd1);
      step(); #1;
    end
    s_ack_i = 1'b1;
    s_dat_i = rd;
    #1;
    check("own_ack", {31'd0, (m == 0) ? m0_ack_o : m1_ack_o}, 32'd1);
    check("other_ack", {31'd0, (m == 0) ? m1_ack_o : m0_ack_o}, 32'd0);
    check("other_dat", (m == 0) ? m1_dat_o : m0_dat_o, 32'd0);
    if (!we) begin
      e = exp_q.pop_front();
      check("rd_dat", (m == 0) ? m0_dat_o : m1_dat_o, e);
    end
    step();
    s_ack_i = 1'b0;
    s_dat_i = '0;
    set_master(m, 1, 0, we, adr, wd);
    #1;
    check("no_err_after_ack", {31'd0, m0_err_o | m1_err_o}, 32'd0);
    step();
    set_master(m, 0, 0, 0, '0, '0);
    #1;
    check("grant_held_at_release", {30'd0, grant_o}, {30'd0, g});
    step(); #1;
    check("grant_idle", {30'd0, grant_o}, 32'd0);
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst_grant", {30'd0, grant_o}, 32'd0);
    check("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    check("rst_errs", {30'd0, m0_err_o, m1_err_o}, 32'd0);
    #20 wb_rst_n_i = 1'b1;

    // Single m0 write.
    access(0, 1, 32'h3000_0000, 32'h0000_00A5, 1, 32'h0);

    // Reset again so the tie starts from reset state. Both masters request together.
    wb_rst_n_i = 1'b0;
    #3 wb_rst_n_i = 1'b1;
    step();
    set_master(0, 1, 1, 0, 32'h3000_0000, '0);
    set_master(1, 1, 1, 0, 32'h3000_0004, '0);
    #1 check("tie_idle", {30'd0, grant_o}, 32'd0);
    step(); #1;
    check("tie_m0_first", {30'd0, grant_o}, 32'd1);
    s_ack_i = 1'b1;
    #1 check("tie_m1_no_ack", {31'd0, m1_ack_o}, 32'd0);
    step();
    s_ack_i = 1'b0;
    set_master(0, 0, 0, 0, '0, '0);
    #1 check("tie_hold_m0", {30'd0, grant_o}, 32'd1);
    step(); #1;
    check("tie_gap", {30'd0, grant_o}, 32'd0);
    step(); #1;
    check("tie_m1_next", {30'd0, grant_o}, 32'd2);
    check("tie_s_adr_m1", s_adr_o, 32'h3000_0004);
    step();
    set_master(1, 0, 0, 0, '0, '0);
    step();
    set_master(0, 1, 1, 0, '0, '0);
    set_master(1, 1, 1, 0, '0, '0);
    #1 check("rr_idle", {30'd0, grant_o}, 32'd0);
    step(); #1;
    check("rr_m0_again", {30'd0, grant_o}, 32'd1);
    step();
    set_master(0, 0, 0, 0, '0, '0);
    set_master(1, 0, 0, 0, '0, '0);
    step(); step();

    // m1 read.
    access(1, 0, 32'h3000_0004, '0, $urandom_range(0, 3), 32'h0000_00C3);

    // m0 read of an unmapped address. The slave never acks and stalls at random.
    step();
    set_master(0, 1, 1, 0, 32'h3000_0010, '0);
    step(); #1;
    check("to_grant", {30'd0, grant_o}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("to_no_err_early", {31'd0, m0_err_o}, 32'd0);
      check("to_stb", {31'd0, s_stb_o}, 32'd1);
      step();
      s_sta_i = 1'($urandom_range(0, 1));
      #1;
    end
    check("to_err", {31'd0, m0_err_o}, 32'd1);
    check("to_m1_err", {31'd0, m1_err_o}, 32'd0);
    check("to_stb_masked", {31'd0, s_stb_o}, 32'd0);
    check("to_no_ack", {31'd0, m0_ack_o}, 32'd0);
    step(); #1;
    check("to_err_one_cycle", {31'd0, m0_err_o}, 32'd0);
    check("to_restrobe", {31'd0, s_stb_o}, 32'd1);
    s_sta_i = 1'b0;
    set_master(0, 0, 0, 0, '0, '0);
    step(); step();

    // Ack arrives in the same cycle that the counter reaches 15.
    access(0, 0, 32'h3000_0008, '0, 15, 32'h1234_5678);

    // Reset while m1 owns the bus with stb high.
    step();
    set_master(1, 1, 1, 0, 32'h3000_0004, '0);
    step(); #1;
    check("mr_grant", {30'd0, grant_o}, 32'd2);
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    #1 check("mr_ack_before", {31'd0, m1_ack_o}, 32'd1);
    wb_rst_n_i = 1'b0;
    #1;
    check("mr_grant_rst", {30'd0, grant_o}, 32'd0);
    check("mr_s_cyc_rst", {31'd0, s_cyc_o}, 32'd0);
    check("mr_m1_ack_rst", {31'd0, m1_ack_o}, 32'd0);
    check("mr_m1_dat_rst", m1_dat_o, 32'd0);
    step();
    s_ack_i = 1'b0;
    s_dat_i = '0;
    wb_rst_n_i = 1'b1;
    set_master(0, 1, 1, 0, '0, '0);
    set_master(1, 1, 1, 0, '0, '0);
    step(); #1;
    check("mr_tie_m0", {30'd0, grant_o}, 32'd1);
    set_master(0, 0, 0, 0, '0, '0);
    set_master(1, 0, 0, 0, '0, '0);
    step();

    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
